// File: rtl/tg_pkg.sv
// Shared FSM encoding, AHB transfer-type constants and the LFSR step used by
// the AHB-Lite traffic generator.
package tg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    FIN     = 3'd5
  } tg_state_t;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [31:0] TG_LFSR_POLY  = 32'h8020_0003;

  // Galois form, right shift: the bit shifted out folds back through the taps.
  function automatic logic [31:0] tg_lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TG_LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/ahb_lite_traffic_gen_if.sv
// AHB-Lite bus bundle between the traffic generator (master) and the slave under test.
interface ahb_lite_traffic_gen_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/tg_lfsr.sv
// 32-bit pattern register for the traffic generator: load restarts the
// sequence from the seed, adv steps it once.
module tg_lfsr
  import tg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] lfsr
);

  // An all-zero state would lock the sequence, so a zero seed becomes 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)     lfsr_d = SEED_EFF;
    else if (adv) lfsr_d = tg_lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/ahb_lite_traffic_gen.sv
// AHB-Lite master running a write-then-readback test over an address window.
// Optional build macro TG_STOP_ON_ERR_EN: end the run after the first logged error.
module ahb_lite_traffic_gen
  import tg_pkg::*;
#(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter int unsigned     WORDS     = 1024,
  parameter int              MODE      = 0,
  parameter logic [31:0]     SEED      = 32'hACE1_0001
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            err_cnt,
  output logic [AW-1:0]          err_addr,
  ahb_lite_traffic_gen_if.master ahb
);

  localparam int          SIZE     = $clog2(DW / 8);
  localparam logic [31:0] LAST_IDX = 32'(WORDS - 1);

`ifdef TG_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  tg_state_t     state_q, state_d;
  logic [31:0]   idx_q, idx_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic [DW-1:0] hwdata_q, hwdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  logic          lfsr_load, lfsr_adv, log_err, last;
  logic [31:0]   lfsr;
  logic [DW-1:0] pat;

  tg_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (HCLK),
    .rst  (HRESET),
    .load (lfsr_load),
    .adv  (lfsr_adv),
    .lfsr (lfsr)
  );

  assign pat  = (MODE == 0) ? idx_q[DW-1:0] : lfsr[DW-1:0];
  assign last = (idx_q == LAST_IDX);

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hwdata_d   = hwdata_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    log_err    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WR_ADDR;
          idx_d      = '0;
          lfsr_load  = 1'b1;
          err_d      = 1'b0;
          err_cnt_d  = '0;
          err_addr_d = '0;
        end
      end
      WR_ADDR: begin
        if (ahb.HREADY) begin
          state_d  = WR_DATA;
          hwdata_d = pat;
        end
      end
      WR_DATA: begin
        if (ahb.HREADY) begin
          log_err  = ahb.HRESP;
          lfsr_adv = 1'b1;
          if (last) begin
            state_d   = RD_ADDR;
            idx_d     = '0;
            lfsr_load = 1'b1;
          end else begin
            state_d = WR_ADDR;
            idx_d   = idx_q + 32'd1;
          end
        end
      end
      RD_ADDR: begin
        if (ahb.HREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (ahb.HREADY) begin
          log_err  = ahb.HRESP || (ahb.HRDATA != pat);
          lfsr_adv = 1'b1;
          if (last) begin
            state_d = FIN;
          end else begin
            state_d = RD_ADDR;
            idx_d   = idx_q + 32'd1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // HADDR still holds the data-phase address, so it names the failing word.
    if (log_err) begin
      err_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (!err_q) err_addr_d = haddr_q;
      if (STOP_ON_ERR) state_d = FIN;
    end
  end

  // Bus and status outputs are registered, so they follow the state being entered.
  always_comb begin
    busy_d   = (state_d != IDLE) && (state_d != FIN);
    done_d   = (state_d == FIN);
    htrans_d = HTRANS_IDLE;
    hwrite_d = hwrite_q;
    haddr_d  = haddr_q;
    unique case (state_d)
      WR_ADDR: begin
        htrans_d = HTRANS_NONSEQ;
        hwrite_d = 1'b1;
        haddr_d  = BASE_ADDR + (AW'(idx_d) << SIZE);
      end
      RD_ADDR: begin
        htrans_d = HTRANS_NONSEQ;
        hwrite_d = 1'b0;
        haddr_d  = BASE_ADDR + (AW'(idx_d) << SIZE);
      end
      IDLE, FIN: hwrite_d = 1'b0;
      default:   ;
    endcase
  end

  // NOTE: reset is synchronous here because the slave side of the test
  // harness samples everything on HCLK; non-blocking updates keep every
  // flop reading the pre-edge values of the others.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      haddr_q    <= BASE_ADDR;
      htrans_q   <= HTRANS_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;

  assign ahb.HADDR     = haddr_q;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HWDATA    = hwdata_q;
  assign ahb.HSIZE     = 3'(SIZE);
  assign ahb.HBURST    = 3'b000;
  assign ahb.HPROT     = 4'b0011;
  assign ahb.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_traffic_gen.sv
// Scoreboard bench for ahb_lite_traffic_gen: two instances (address pattern with
// a fault-injecting wait-state slave, LFSR pattern with a plain slave).
module tb_ahb_lite_traffic_gen;

  localparam int          W_A    = 4;
  localparam logic [31:0] BASE_A = 32'h100;
  localparam int          W_B    = 2;
  localparam logic [31:0] BASE_B = 32'h200;

`ifdef TG_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } txn_t;

  logic        HCLK   = 1'b0;
  logic        HRESET = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [15:0] err_cnt_a, err_cnt_b;
  logic [31:0] err_addr_a, err_addr_b;

  ahb_lite_traffic_gen_if #(.AW(32), .DW(32)) bus_a ();
  ahb_lite_traffic_gen_if #(.AW(32), .DW(32)) bus_b ();

  always #5 HCLK = ~HCLK;

  ahb_lite_traffic_gen #(
    .AW(32), .DW(32), .BASE_ADDR(BASE_A), .WORDS(W_A), .MODE(0), .SEED(32'hACE1_0001)
  ) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .start(start_a), .busy(busy_a), .done(done_a),
    .err(err_a), .err_cnt(err_cnt_a), .err_addr(err_addr_a), .ahb(bus_a)
  );

  ahb_lite_traffic_gen #(
    .AW(32), .DW(32), .BASE_ADDR(BASE_B), .WORDS(W_B), .MODE(1), .SEED(32'h1)
  ) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .start(start_b), .busy(busy_b), .done(done_b),
    .err(err_b), .err_cnt(err_cnt_b), .err_addr(err_addr_b), .ahb(bus_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return BASE_A + 32'(i) * 32'd4;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  // ---------------- slave A: memory with wait states and fault injection
  logic [31:0] mem_a [0:63];
  bit          s_dphase, s_wr;
  logic [31:0] s_addr;
  int          s_wait;
  int          cfg_waits = 0, cfg_corrupt = -1, cfg_hresp_wr = -1, total_waits = 0;
  bit          cfg_rand = 1'b0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      s_dphase     = 1'b0;
      bus_a.HREADY = 1'b1;
      bus_a.HRESP  = 1'b0;
      bus_a.HRDATA = 32'h0;
    end else begin
      bus_a.HREADY = !(s_dphase && s_wait > 0);
      bus_a.HRESP  = s_dphase && s_wr && (cfg_hresp_wr >= 0) && (s_addr == addr_of(cfg_hresp_wr));
      bus_a.HRDATA = 32'h0;
      if (s_dphase && !s_wr)
        bus_a.HRDATA = mem_a[s_addr[7:2]] ^
          (((cfg_corrupt >= 0) && (s_addr == addr_of(cfg_corrupt))) ? 32'hDEAD_0000 : 32'h0);
      if (bus_a.HREADY) begin
        if (s_dphase && s_wr) mem_a[s_addr[7:2]] = bus_a.HWDATA;
        if (bus_a.HTRANS == 2'b10) begin
          s_dphase = 1'b1;
          s_wr     = bus_a.HWRITE;
          s_addr   = bus_a.HADDR;
          s_wait   = cfg_rand ? int'($urandom_range(3, 0)) : cfg_waits;
          total_waits += s_wait;
        end else begin
          s_dphase = 1'b0;
        end
      end else begin
        s_wait--;
      end
    end
  end

  // ---------------- monitor A: pops the expected transfer on each data phase
  txn_t        exp_a[$];
  bit          m_dphase, m_first, m_wr;
  logic [31:0] m_addr, m_wdata;
  int          done_cnt_a = 0;

  always @(negedge HCLK) begin
    txn_t t;
    #2;
    if (HRESET) begin
      m_dphase = 1'b0;
    end else begin
      if (m_dphase) begin
        check("a_htrans_idle_in_data", {30'b0, bus_a.HTRANS}, 32'h0);
        if (m_first) begin
          m_wdata = bus_a.HWDATA;
        end else begin
          check("a_haddr_hold", bus_a.HADDR, m_addr);
          if (m_wr) check("a_hwdata_hold", bus_a.HWDATA, m_wdata);
        end
        m_first = 1'b0;
        if (bus_a.HREADY) begin
          check("a_exp_q_nonempty", 32'(exp_a.size() > 0), 32'h1);
          if (exp_a.size() > 0) begin
            t = exp_a.pop_front();
            check("a_xfer_addr", m_addr, t.addr);
            check("a_xfer_write", {31'b0, m_wr}, {31'b0, t.wr});
            if (t.wr) check("a_xfer_hwdata", bus_a.HWDATA, t.data);
          end
          m_dphase = 1'b0;
        end
      end
      if (bus_a.HREADY && bus_a.HTRANS == 2'b10) begin
        m_dphase = 1'b1;
        m_first  = 1'b1;
        m_addr   = bus_a.HADDR;
        m_wr     = bus_a.HWRITE;
      end
      if (done_a) done_cnt_a++;
    end
  end

  // ---------------- slave B and monitor B: zero-wait memory, LFSR data
  logic [31:0] mem_b [0:3];
  bit          sb_dphase, sb_wr, mb_dphase, mb_wr;
  logic [31:0] sb_addr, mb_addr;
  txn_t        exp_b[$];

  always @(negedge HCLK) begin
    bus_b.HREADY = 1'b1;
    bus_b.HRESP  = 1'b0;
    bus_b.HRDATA = (sb_dphase && !sb_wr) ? mem_b[sb_addr[3:2]] : 32'h0;
    if (sb_dphase && sb_wr) mem_b[sb_addr[3:2]] = bus_b.HWDATA;
    sb_dphase = !HRESET && (bus_b.HTRANS == 2'b10);
    sb_wr     = bus_b.HWRITE;
    sb_addr   = bus_b.HADDR;
  end

  always @(negedge HCLK) begin
    txn_t t;
    #2;
    if (HRESET) begin
      mb_dphase = 1'b0;
    end else begin
      if (mb_dphase && bus_b.HREADY) begin
        check("b_exp_q_nonempty", 32'(exp_b.size() > 0), 32'h1);
        if (exp_b.size() > 0) begin
          t = exp_b.pop_front();
          check("b_xfer_addr", mb_addr, t.addr);
          check("b_xfer_write", {31'b0, mb_wr}, {31'b0, t.wr});
          if (t.wr) check("b_xfer_hwdata", bus_b.HWDATA, t.data);
        end
        mb_dphase = 1'b0;
      end
      if (bus_b.HREADY && bus_b.HTRANS == 2'b10) begin
        mb_dphase = 1'b1;
        mb_addr   = bus_b.HADDR;
        mb_wr     = bus_b.HWRITE;
      end
    end
  end

  // ---------------- stimulus for instance A with its reference model
  task automatic run_a(input string tag, input int waits, input bit rnd,
                       input int corrupt, input int hresp_wr, input bit extra_start);
    int          ntx, nerr, start_cyc, done_cyc;
    logic [31:0] first_addr;
    bit          seen;
    nerr       = int'(hresp_wr >= 0) + int'(corrupt >= 0);
    first_addr = (hresp_wr >= 0) ? addr_of(hresp_wr) : (corrupt >= 0) ? addr_of(corrupt) : 32'h0;
    ntx        = 2 * W_A;
    if (STOP && nerr > 0) begin
      ntx  = (hresp_wr >= 0) ? hresp_wr + 1 : W_A + corrupt + 1;
      nerr = 1;
    end
    for (int n = 0; n < ntx; n++) begin
      txn_t t;
      t.addr = addr_of(n % W_A);
      t.wr   = (n < W_A);
      t.data = 32'(n % W_A);
      exp_a.push_back(t);
    end
    cfg_waits    = waits;
    cfg_rand     = rnd;
    cfg_corrupt  = corrupt;
    cfg_hresp_wr = hresp_wr;
    total_waits  = 0;

    @(negedge HCLK);
    start_a = 1'b1;
    @(negedge HCLK);
    start_a   = 1'b0;
    start_cyc = cyc;
    check({tag, "_busy_running"}, {31'b0, busy_a}, 32'h1);
    seen     = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < 2000; k++) begin
      start_a = extra_start && (k == 6);
      @(negedge HCLK);
      if (done_a) begin
        seen     = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    start_a = 1'b0;
    check({tag, "_done_seen"}, {31'b0, seen}, 32'h1);
    if (seen) begin
      check({tag, "_run_cycles"}, 32'(done_cyc - start_cyc + 2), 32'(2 * ntx + total_waits + 2));
      check({tag, "_busy_at_done"}, {31'b0, busy_a}, 32'h0);
      check({tag, "_err"}, {31'b0, err_a}, {31'b0, nerr > 0});
      check({tag, "_err_cnt"}, {16'b0, err_cnt_a}, 32'(nerr));
      check({tag, "_err_addr"}, err_addr_a, first_addr);
      @(negedge HCLK);
      check({tag, "_done_one_cycle"}, {31'b0, done_a}, 32'h0);
      repeat (4) @(negedge HCLK);
      check({tag, "_all_xfers_seen"}, 32'(exp_a.size()), 32'h0);
    end
    exp_a.delete();
  endtask

  task automatic run_b();
    logic [31:0] s;
    int          start_cyc;
    bit          seen;
    s = 32'h1;
    for (int n = 0; n < 2 * W_B; n++) begin
      txn_t t;
      if (n == W_B) s = 32'h1;
      t.addr = BASE_B + 32'(n % W_B) * 32'd4;
      t.wr   = (n < W_B);
      t.data = s;
      exp_b.push_back(t);
      s = lfsr_step(s);
    end
    @(negedge HCLK);
    start_b = 1'b1;
    @(negedge HCLK);
    start_b   = 1'b0;
    start_cyc = cyc;
    seen      = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge HCLK);
      if (done_b) begin
        seen = 1'b1;
        check("b_run_cycles", 32'(cyc - start_cyc + 2), 32'(4 * W_B + 2));
        break;
      end
    end
    check("b_done_seen", {31'b0, seen}, 32'h1);
    check("b_err", {31'b0, err_b}, 32'h0);
    check("b_err_cnt", {16'b0, err_cnt_b}, 32'h0);
    repeat (3) @(negedge HCLK);
    check("b_all_xfers_seen", 32'(exp_b.size()), 32'h0);
  endtask

  task automatic reset_mid_run();
    bit found;
    int dc0;
    for (int n = 0; n < 2 * W_A; n++) begin
      txn_t t;
      t.addr = addr_of(n % W_A);
      t.wr   = (n < W_A);
      t.data = 32'(n % W_A);
      exp_a.push_back(t);
    end
    cfg_waits = 0; cfg_rand = 1'b0; cfg_corrupt = -1; cfg_hresp_wr = -1;
    @(negedge HCLK);
    start_a = 1'b1;
    @(negedge HCLK);
    start_a = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus_a.HTRANS == 2'b10 && !bus_a.HWRITE) begin
        found = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    check("rst_read_addr_reached", {31'b0, found}, 32'h1);
    @(negedge HCLK);
    check("rst_in_read_data", {30'b0, bus_a.HTRANS}, 32'h0);
    HRESET = 1'b1;
    dc0    = done_cnt_a;
    @(negedge HCLK);
    check("rst_htrans_idle", {30'b0, bus_a.HTRANS}, 32'h0);
    check("rst_busy", {31'b0, busy_a}, 32'h0);
    check("rst_haddr", bus_a.HADDR, BASE_A);
    check("rst_hwdata", bus_a.HWDATA, 32'h0);
    HRESET = 1'b0;
    exp_a.delete();
    repeat (12) @(negedge HCLK);
    check("rst_no_done", 32'(done_cnt_a - dc0), 32'h0);
    check("rst_stays_idle", {30'b0, bus_a.HTRANS}, 32'h0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge HCLK);
    check("reset_htrans", {30'b0, bus_a.HTRANS}, 32'h0);
    check("reset_hwrite", {31'b0, bus_a.HWRITE}, 32'h0);
    check("reset_haddr", bus_a.HADDR, BASE_A);
    check("reset_hwdata", bus_a.HWDATA, 32'h0);
    check("reset_busy", {31'b0, busy_a}, 32'h0);
    check("reset_done", {31'b0, done_a}, 32'h0);
    check("reset_err", {31'b0, err_a}, 32'h0);
    check("reset_err_cnt", {16'b0, err_cnt_a}, 32'h0);
    check("reset_err_addr", err_addr_a, 32'h0);
    check("const_hsize", {29'b0, bus_a.HSIZE}, 32'h2);
    check("const_hburst", {29'b0, bus_a.HBURST}, 32'h0);
    check("const_hprot", {28'b0, bus_a.HPROT}, 32'h3);
    check("const_hmastlock", {31'b0, bus_a.HMASTLOCK}, 32'h0);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);

    run_a("basic", 0, 1'b0, -1, -1, 1'b0);
    run_b();
    run_a("wait3", 3, 1'b0, -1, -1, 1'b0);
    run_a("corrupt_w2", 0, 1'b0, 2, -1, 1'b0);
    run_a("hresp_wr1", 0, 1'b0, -1, 1, 1'b0);
    run_a("start_while_busy", 0, 1'b0, -1, -1, 1'b1);
    reset_mid_run();
    run_a("after_reset", 0, 1'b0, -1, -1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      int c, h;
      c = int'($urandom_range(W_A, 0));
      h = int'($urandom_range(W_A + 1, 0));
      run_a($sformatf("rand%0d", r), 0, 1'b1, (c == W_A) ? -1 : c, (h >= W_A) ? -1 : h, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
